// File: rtl/nand2_resp_checker_if.sv
// Bundle of signals between the NAND2 stimulus/DUT side and the response checker.
// The master side drives stimulus, DUT output and start; the slave (checker) returns status.
interface nand2_resp_checker_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic             A;
   logic             B;
   logic             Y;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] chk_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic [3:0]       cov;
   logic [2:0]       first_err;

   modport master (
      output start, A, B, Y,
      input  done, pass, chk_cnt, err_cnt, cov, first_err
   );

   modport slave (
      input  start, A, B, Y,
      output done, pass, chk_cnt, err_cnt, cov, first_err
   );
endinterface

// File: rtl/nand2_resp_checker.sv
// nand2_resp_checker: registers {A,B} and Y, waits for the inputs to be stable for
// SETTLE cycles, checks Y against ~(A&B), and tracks check/error counts plus coverage
// of the four input combinations. A run ends on full coverage or on timeout.
// Optional macro NAND2_CHK_LOG_EN adds a simulation-only trace of every check and a
// summary line on run completion; behaviour and ports are identical either way.
module nand2_resp_checker #(
   parameter int SETTLE  = 2,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   nand2_resp_checker_if.slave   bus
);

   // Settle counter only needs to reach SETTLE-1; timeout counter only TIMEOUT-1.
   localparam int                SC_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SC_W-1:0]   SC_LAST = SC_W'(SETTLE - 1);
   localparam int                TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TO_W-1:0]   TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_CHECK, S_HOLD, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [1:0]       r_ab_q, r_ab_d;
   logic             r_y_q, r_y_d;
   logic [1:0]       prev_ab_q, prev_ab_d;
   logic [SC_W-1:0]  settle_cnt_q, settle_cnt_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [3:0]       cov_q, cov_d;
   logic [2:0]       first_err_q, first_err_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             timeout_q, timeout_d;

   logic             ab_changed;
   logic             mismatch;
   logic             to_hit;
   logic             begin_run;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   assign ab_changed = (r_ab_q != prev_ab_q);
   // Case inequality so an X/Z on Y is reported as a mismatch.
   assign mismatch   = (r_y_q !== ~(r_ab_q[1] & r_ab_q[0]));
   assign to_hit     = (TIMEOUT != 0) && (to_cnt_q == TO_LAST);
   assign begin_run  = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

   // Next-state and datapath updates for the check sequencer.
   always_comb begin
      state_d      = state_q;
      r_ab_d       = {bus.A, bus.B};
      r_y_d        = bus.Y;
      prev_ab_d    = r_ab_q;
      settle_cnt_d = settle_cnt_q;
      to_cnt_d     = to_cnt_q;
      chk_cnt_d    = chk_cnt_q;
      err_cnt_d    = err_cnt_q;
      cov_d        = cov_q;
      first_err_d  = first_err_q;
      done_d       = done_q;
      pass_d       = pass_q;
      timeout_d    = timeout_q;

      case (state_q)
         S_SETTLE: begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (to_hit) begin
               state_d   = S_DONE;
               done_d    = 1'b1;
               pass_d    = 1'b0;
               timeout_d = 1'b1;
            end else if (ab_changed) begin
               settle_cnt_d = '0;
            end else if (settle_cnt_q == SC_LAST) begin
               settle_cnt_d = '0;
               state_d      = S_CHECK;
            end else begin
               settle_cnt_d = settle_cnt_q + 1'b1;
            end
         end
         S_CHECK: begin
            to_cnt_d        = '0;
            chk_cnt_d       = sat_inc(chk_cnt_q);
            cov_d[r_ab_q]   = 1'b1;
            if (mismatch) begin
               err_cnt_d = sat_inc(err_cnt_q);
               if (err_cnt_q == '0) first_err_d = {r_ab_q, r_y_q};
            end
            if (cov_d == 4'hF) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               pass_d  = (err_cnt_d == '0) && !timeout_q;
            end else begin
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (to_hit) begin
               state_d   = S_DONE;
               done_d    = 1'b1;
               pass_d    = 1'b0;
               timeout_d = 1'b1;
            end else if (ab_changed) begin
               settle_cnt_d = '0;
               state_d      = S_SETTLE;
            end
         end
         S_IDLE, S_DONE: ;
         default: state_d = S_IDLE;
      endcase

      // A start from IDLE or DONE clears the previous run's results.
      if (begin_run) begin
         state_d      = S_SETTLE;
         settle_cnt_d = '0;
         to_cnt_d     = '0;
         chk_cnt_d    = '0;
         err_cnt_d    = '0;
         cov_d        = '0;
         first_err_d  = '0;
         done_d       = 1'b0;
         pass_d       = 1'b0;
         timeout_d    = 1'b0;
      end
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         r_ab_q       <= '0;
         r_y_q        <= 1'b0;
         prev_ab_q    <= '0;
         settle_cnt_q <= '0;
         to_cnt_q     <= '0;
         chk_cnt_q    <= '0;
         err_cnt_q    <= '0;
         cov_q        <= '0;
         first_err_q  <= '0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         r_ab_q       <= r_ab_d;
         r_y_q        <= r_y_d;
         prev_ab_q    <= prev_ab_d;
         settle_cnt_q <= settle_cnt_d;
         to_cnt_q     <= to_cnt_d;
         chk_cnt_q    <= chk_cnt_d;
         err_cnt_q    <= err_cnt_d;
         cov_q        <= cov_d;
         first_err_q  <= first_err_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         timeout_q    <= timeout_d;
      end
   end

   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.chk_cnt   = chk_cnt_q;
   assign bus.err_cnt   = err_cnt_q;
   assign bus.cov       = cov_q;
   assign bus.first_err = first_err_q;

`ifdef NAND2_CHK_LOG_EN
   // Simulation trace of each check and of run completion.
   always_ff @(posedge clk) begin
      if (!rst && state_q == S_CHECK)
         $display("t=%0t A=%b B=%b Y=%b exp=%b %s", $time, r_ab_q[1], r_ab_q[0], r_y_q,
                  ~(r_ab_q[1] & r_ab_q[0]), mismatch ? "FAIL" : "OK");
      if (!rst && state_q != S_DONE && state_d == S_DONE)
         $display("t=%0t nand2 check run complete: checks=%0d errors=%0d cov=%b pass=%b",
                  $time, chk_cnt_d, err_cnt_d, cov_d, pass_d);
   end
`endif

endmodule
